bp_me_io_cmd_arb_mux: RTL and testbench

// - Merges num_src_p single-beat IO command streams (NBF loader, CFG loader, host, debug) onto one IO command link.
// - Steers each response back to the source that issued the matching command.
// - Supersedes hard-wired two-way mutex muxing of loader traffic.
// - Tracks outstanding commands in an in-order source-ID FIFO, so sources may overlap in time.

---
 rtl/bp_me_io_cmd_arb_mux.sv | 134 +++++++++++++
 tb/tb_bp_me_io_cmd_arb_mux.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bp_me_io_cmd_arb_mux.sv
// rtl/bp_me_io_cmd_arb_mux.sv - merges N IO command sources onto one link and routes responses back in order.
// Optional round-robin grant via BP_IO_ARB_ROUND_ROBIN_EN; default is fixed priority (lowest index wins).
module bp_me_io_cmd_arb_mux #(
    parameter int num_src_p         = 3,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_src_p*msg_width_p-1:0] src_cmd_i,
    input  logic [num_src_p-1:0]             src_cmd_v_i,
    output logic [num_src_p-1:0]             src_cmd_ready_o,
    output logic [num_src_p*msg_width_p-1:0] src_resp_o,
    output logic [num_src_p-1:0]             src_resp_v_o,
    input  logic [num_src_p-1:0]             src_resp_ready_i,
    output logic [msg_width_p-1:0]           io_cmd_o,
    output logic                             io_cmd_v_o,
    input  logic                             io_cmd_ready_i,
    input  logic [msg_width_p-1:0]           io_resp_i,
    input  logic                             io_resp_v_i,
    output logic                             io_resp_yumi_o,
    output logic [$clog2(max_outstanding_p+1)-1:0] pending_o,
    output logic                             error_o
);

    localparam int id_w_lp  = (num_src_p > 1) ? $clog2(num_src_p) : 1;
    localparam int ptr_w_lp = $clog2(max_outstanding_p);
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

    logic [id_w_lp-1:0]  grant;
    logic                any_v, fifo_full, fifo_empty, cmd_xfer, resp_pop;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [id_w_lp-1:0]  id_mem_q [max_outstanding_p];
    logic [id_w_lp-1:0]  head_id;

`ifdef BP_IO_ARB_ROUND_ROBIN_EN
    logic [id_w_lp-1:0] rr_q, rr_d;

    always_comb begin : grant_sel
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < num_src_p; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= num_src_p) idx = idx - num_src_p;
            if (!found && src_cmd_v_i[idx]) begin
                grant = id_w_lp'(idx);
                found = 1'b1;
            end
        end
    end

    // Pointer only advances on an accepted transfer, so a stalled grant stays put.
    always_comb begin
        rr_d = rr_q;
        if (cmd_xfer) rr_d = (int'(grant) == num_src_p - 1) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rr_q <= '0;
        else            rr_q <= rr_d;
    end
`else
    always_comb begin
        grant = '0;
        for (int s = num_src_p - 1; s >= 0; s--) begin
            if (src_cmd_v_i[s]) grant = id_w_lp'(s);
        end
    end
`endif

    assign any_v      = |src_cmd_v_i;
    assign fifo_full  = (cnt_q == cnt_w_lp'(max_outstanding_p));
    assign fifo_empty = (cnt_q == '0);
    assign head_id    = id_mem_q[rptr_q];

    // Valid must not depend on io_cmd_ready_i; full blocks even when a pop is concurrent.
    assign io_cmd_v_o = reset_n_i & any_v & ~fifo_full;
    assign io_cmd_o   = src_cmd_i[grant*msg_width_p +: msg_width_p];
    assign cmd_xfer   = io_cmd_v_o & io_cmd_ready_i;

    always_comb begin
        src_cmd_ready_o = '0;
        if (reset_n_i && any_v && !fifo_full && io_cmd_ready_i) src_cmd_ready_o[grant] = 1'b1;
    end

    assign src_resp_o = {num_src_p{io_resp_i}};

    always_comb begin
        src_resp_v_o = '0;
        if (reset_n_i && io_resp_v_i && !fifo_empty) src_resp_v_o[head_id] = 1'b1;
    end

    // A response with nothing outstanding is swallowed so the link cannot wedge.
    assign resp_pop       = reset_n_i & io_resp_v_i & ~fifo_empty & src_resp_ready_i[head_id];
    assign io_resp_yumi_o = resp_pop | (reset_n_i & io_resp_v_i & fifo_empty);

    always_comb begin
        wptr_d = wptr_q + ptr_w_lp'(cmd_xfer);
        rptr_d = rptr_q + ptr_w_lp'(resp_pop);
        err_d  = err_q | (io_resp_v_i & fifo_empty);
        case ({cmd_xfer, resp_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cmd_xfer) id_mem_q[wptr_q] <= grant;
    end

    assign pending_o = cnt_q;
    assign error_o   = err_q;

endmodule

// File: tb/tb_bp_me_io_cmd_arb_mux.sv
// tb/tb_bp_me_io_cmd_arb_mux.sv - scoreboard bench for bp_me_io_cmd_arb_mux.
module tb_bp_me_io_cmd_arb_mux;

    localparam int N   = 3;
    localparam int W   = 128;
    localparam int MAX = 8;

    logic           clk, rst_n;
    logic [N*W-1:0] src_cmd, src_resp;
    logic [N-1:0]   src_v, src_cmd_ready, src_resp_v, src_resp_ready;
    logic [W-1:0]   io_cmd, io_resp;
    logic           io_cmd_v, io_cmd_ready, io_resp_v, yumi, error;
    logic [3:0]     pending;

    bp_me_io_cmd_arb_mux #(.num_src_p(N), .msg_width_p(W), .max_outstanding_p(MAX)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .src_cmd_i(src_cmd), .src_cmd_v_i(src_v), .src_cmd_ready_o(src_cmd_ready),
        .src_resp_o(src_resp), .src_resp_v_o(src_resp_v), .src_resp_ready_i(src_resp_ready),
        .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_ready_i(io_cmd_ready),
        .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_yumi_o(yumi),
        .pending_o(pending), .error_o(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           rst;
        bit           cmd_v;
        bit           chk_rdy;
        logic [N-1:0] cmd_rdy;
        logic [W-1:0] cmd;
        logic [N-1:0] resp_v;
        logic [W-1:0] resp;
        bit           yumi;
        int           pend;
        bit           err;
    } exp_t;

    exp_t exp_q[$];
    int   id_q[$];
    bit   err_m;
    int   rr_m;
    int   n_vec, n_err;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
`ifdef BP_IO_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) if (v[(rr_m + k) % N]) return (rr_m + k) % N;
`else
        for (int s = 0; s < N; s++) if (v[s]) return s;
`endif
        return -1;
    endfunction

    task automatic randomize_data();
        for (int s = 0; s < N; s++) src_cmd[s*W +: W] = {$urandom, $urandom, $urandom, $urandom};
        io_resp = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One cycle of stimulus; expectations come from the queue model before it advances.
    task automatic step(input logic [N-1:0] v, input bit cr, input bit rv, input logic [N-1:0] rdy);
        exp_t e;
        int   g, sz;
        bit   full, pop;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        randomize_data();
        src_v = v; io_cmd_ready = cr; io_resp_v = rv; src_resp_ready = rdy;
        sz   = id_q.size();
        full = (sz == MAX);
        g    = pick(v);
        e.rst     = 0;
        e.cmd_v   = (g >= 0) && !full;
        e.chk_rdy = (g >= 0);
        e.cmd     = (g >= 0) ? src_cmd[g*W +: W] : '0;
        e.cmd_rdy = (e.cmd_v && cr) ? N'(1 << g) : '0;
        e.resp_v  = (rv && sz > 0) ? N'(1 << id_q[0]) : '0;
        pop       = rv && sz > 0 && rdy[id_q[0]];
        e.yumi    = pop || (rv && sz == 0);
        e.resp    = io_resp;
        e.pend    = sz;
        e.err     = err_m;
        exp_q.push_back(e);
        if (rv && sz == 0) err_m = 1;
        if (pop) void'(id_q.pop_front());
        if (e.cmd_v && cr) begin
            id_q.push_back(g);
            rr_m = (g + 1) % N;
        end
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        randomize_data();
        src_v = '1; io_cmd_ready = 1; io_resp_v = 1; src_resp_ready = '1;
        rst_n = 1'b0;
        e = '{rst: 1, cmd_v: 0, chk_rdy: 1, cmd_rdy: '0, cmd: '0, resp_v: '0,
              resp: '0, yumi: 0, pend: 0, err: 0};
        exp_q.push_back(e);
        id_q.delete();
        err_m = 0;
        rr_m  = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < MAX + 2; i++) step('0, 1, 1, '1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("io_cmd_v", W'(io_cmd_v), W'(e.cmd_v));
            if (e.chk_rdy) chk("src_cmd_ready", W'(src_cmd_ready), W'(e.cmd_rdy));
            if (e.cmd_v && !e.rst) chk("io_cmd", io_cmd, e.cmd);
            chk("src_resp_v", W'(src_resp_v), W'(e.resp_v));
            if (e.resp_v != 0) chk("src_resp", src_resp, {N{e.resp}});
            chk("yumi", W'(yumi), W'(e.yumi));
            chk("pending", W'(pending), W'(e.pend));
            chk("error", W'(error), W'(e.err));
        end
    end

    initial begin
        n_vec = 0; n_err = 0; err_m = 0; rr_m = 0;
        rst_n = 0; src_v = '0; io_cmd_ready = 0; io_resp_v = 0; src_resp_ready = '0;
        src_cmd = '0; io_resp = '0;
        repeat (2) @(posedge clk);
        do_reset();
        // Spurious response on an empty FIFO, then sticky error.
        step('0, 1, 1, '1);
        step('0, 1, 0, '1);
        step(3'b001, 1, 0, '1);
        do_reset();
        // Single source: four commands out, four responses back.
        repeat (4) step(3'b010, 1, 0, '1);
        step('0, 1, 0, '1);
        repeat (4) step('0, 1, 1, '1);
        step('0, 1, 0, '1);
        // Contention between src0 and src2.
        repeat (8) step(3'b101, 1, 1, '1);
        drain();
        // Fill to capacity, then request while popping in the same cycle.
        repeat (MAX) step(N'($urandom_range(1, 7)), 1, 0, '1);
        step(3'b111, 1, 1, '1);
        step(3'b111, 1, 0, '1);
        step('0, 1, 0, '1);
        drain();
        // Head-of-line backpressure: src2 at head, src0 behind it.
        step(3'b100, 1, 0, '1);
        step(3'b001, 1, 0, '1);
        repeat (5) step('0, 1, 1, 3'b011);
        step('0, 1, 1, '1);
        step('0, 1, 1, '1);
        step('0, 1, 0, '1);
        // Reset with commands in flight.
        repeat (3) step(3'b111, 1, 0, '1);
        do_reset();
        step('0, 0, 0, '0);
        // Randomized traffic with varying response pressure.
        for (int blk = 0; blk < 30; blk++) begin
            int rp;
            rp = $urandom_range(0, 100);
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 399) == 0) do_reset();
                else step(N'($urandom), ($urandom % 4) != 0, $urandom_range(0, 99) < rp, N'($urandom | $urandom));
            end
        end
        drain();
        @(posedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
